// File: rtl/cnn_pkg.sv
// Shared constants and types for the FC classification path.
// fc_argmax optionally builds score readback storage under FC_ARGMAX_READBACK_EN.
package cnn_pkg;
    localparam int DATA_WIDTH = 12;
    localparam int OUTPUT_NUM = 10;
    localparam int IDX_WIDTH  = 4;

    typedef logic signed [DATA_WIDTH-1:0] score_t;
    typedef logic [IDX_WIDTH-1:0]         cls_idx_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;
endpackage

// File: rtl/fc_argmax_if.sv
// Score stream and classification result bundle between the FC layer and fc_argmax.
// Stream is valid-only (no ready): every cycle with valid_in high delivers one score that is always consumed.
interface fc_argmax_if;
    import cnn_pkg::*;

    logic     valid_in;
    score_t   data_in;
    logic     clear;
    cls_idx_t rd_addr;
    cls_idx_t decision;
    score_t   max_score;
    logic     valid_out;
    logic     busy;
    score_t   rd_data;
    state_t   dbg_state;

    modport master (
        output valid_in, data_in, clear, rd_addr,
        input  decision, max_score, valid_out, busy, rd_data, dbg_state
    );

    modport slave (
        input  valid_in, data_in, clear, rd_addr,
        output decision, max_score, valid_out, busy, rd_data, dbg_state
    );
endinterface

// File: rtl/fc_score_cmp.sv
// Running-maximum step: candidate replaces the current best only when strictly greater (signed),
// so ties keep the earlier (lower) class index.
module fc_score_cmp
    import cnn_pkg::*;
(
    input  score_t   best_val_i,
    input  cls_idx_t best_idx_i,
    input  score_t   cand_val_i,
    input  cls_idx_t cand_idx_i,
    output score_t   best_val_o,
    output cls_idx_t best_idx_o
);
    logic take_cand;

    assign take_cand  = (cand_val_i > best_val_i);
    assign best_val_o = take_cand ? cand_val_i : best_val_i;
    assign best_idx_o = take_cand ? cand_idx_i : best_idx_i;
endmodule

// File: rtl/fc_argmax.sv
// Argmax over one frame of OUTPUT_NUM signed class scores, one-cycle valid pulse per frame.
// Define FC_ARGMAX_READBACK_EN to build per-class score storage readable through rd_addr/rd_data.
module fc_argmax
    import cnn_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    fc_argmax_if.slave  bus
);
    localparam cls_idx_t LAST_IDX = cls_idx_t'(OUTPUT_NUM - 1);

    state_t   state_q;
    cls_idx_t cnt_q;
    score_t   best_val_q;
    cls_idx_t best_idx_q;
    cls_idx_t decision_q;
    score_t   max_score_q;
    logic     valid_out_q;

    logic     first_beat;
    cls_idx_t slot;
    logic     last_beat;
    score_t   cmp_val;
    cls_idx_t cmp_idx;
    score_t   best_val_d;
    cls_idx_t best_idx_d;

    // A clear in the same cycle as a beat makes that beat class 0 of a fresh frame.
    assign first_beat = bus.clear || (state_q == ST_IDLE);
    assign slot       = first_beat ? '0 : cnt_q;
    assign last_beat  = (slot == LAST_IDX);

    fc_score_cmp u_cmp (
        .best_val_i (best_val_q),
        .best_idx_i (best_idx_q),
        .cand_val_i (bus.data_in),
        .cand_idx_i (cnt_q),
        .best_val_o (cmp_val),
        .best_idx_o (cmp_idx)
    );

    assign best_val_d = first_beat ? bus.data_in : cmp_val;
    assign best_idx_d = first_beat ? '0 : cmp_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            best_val_q  <= '0;
            best_idx_q  <= '0;
            decision_q  <= '0;
            max_score_q <= '0;
            valid_out_q <= 1'b0;
        end else begin
            valid_out_q <= 1'b0;
            if (bus.valid_in) begin
                best_val_q <= best_val_d;
                best_idx_q <= best_idx_d;
                if (last_beat) begin
                    decision_q  <= best_idx_d;
                    max_score_q <= best_val_d;
                    valid_out_q <= 1'b1;
                    cnt_q       <= '0;
                    state_q     <= ST_IDLE;
                end else begin
                    cnt_q   <= slot + cls_idx_t'(1);
                    state_q <= ST_ACCUM;
                end
            end else if (bus.clear) begin
                cnt_q   <= '0;
                state_q <= ST_IDLE;
            end
        end
    end

`ifdef FC_ARGMAX_READBACK_EN
    localparam logic [IDX_WIDTH:0] NUM_SLOTS = (IDX_WIDTH+1)'(OUTPUT_NUM);

    score_t score_mem [OUTPUT_NUM];

    // Storage survives clear; only reset wipes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < OUTPUT_NUM; i++) begin
                score_mem[i] <= '0;
            end
        end else if (bus.valid_in) begin
            score_mem[slot] <= bus.data_in;
        end
    end

    assign bus.rd_data = ({1'b0, bus.rd_addr} < NUM_SLOTS) ? score_mem[bus.rd_addr] : '0;
`else
    logic unused_rd_addr;

    assign unused_rd_addr = ^bus.rd_addr;
    assign bus.rd_data    = '0;
`endif

    assign bus.decision  = decision_q;
    assign bus.max_score = max_score_q;
    assign bus.valid_out = valid_out_q;
    assign bus.busy      = (state_q == ST_ACCUM);
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_fc_argmax.sv
// Self-checking bench for fc_argmax: scoreboard of expected {decision, max_score} per completed frame.
module tb_fc_argmax;
    import cnn_pkg::*;

    localparam int EXP_W = IDX_WIDTH + DATA_WIDTH;

    logic clk;
    logic rst;
    int   cyc;
    int   tests_run;
    int   fails;
    logic prev_vo;

    logic [EXP_W-1:0] exp_q[$];
    int               pulse_q[$];

    fc_argmax_if bus ();

    fc_argmax dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && bus.valid_out) begin
            pulse_q.push_back(cyc);
            if (prev_vo) begin
                fails++;
                $display("FAIL pulse_width: valid_out high two cycles in a row at cycle %0d", cyc);
            end
            tests_run++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_valid_out: got dec=%0d score=%0d, none expected",
                         bus.decision, bus.max_score);
            end else begin
                logic [EXP_W-1:0] e;
                e = exp_q.pop_front();
                if ({bus.decision, bus.max_score} !== e) begin
                    fails++;
                    $display("FAIL frame_result: got dec=%0d score=%0d, expected dec=%0d score=%0d",
                             bus.decision, bus.max_score, e[EXP_W-1 -: IDX_WIDTH],
                             $signed(e[DATA_WIDTH-1:0]));
                end
            end
        end
        prev_vo = bus.valid_out & ~rst;
    end

    // Driver tasks
    task automatic beat(input int v, input logic clr);
        bus.valid_in = 1'b1;
        bus.data_in  = score_t'(v);
        bus.clear    = clr;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        bus.clear    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_only();
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
    endtask

    function automatic logic [EXP_W-1:0] expect_of(input int s[OUTPUT_NUM]);
        int b;
        b = 0;
        for (int i = 1; i < OUTPUT_NUM; i++) begin
            if (s[i] > s[b]) b = i;
        end
        return {cls_idx_t'(b), score_t'(s[b])};
    endfunction

    task automatic run_frame(input int s[OUTPUT_NUM], input int max_gap);
        exp_q.push_back(expect_of(s));
        for (int i = 0; i < OUTPUT_NUM; i++) begin
            beat(s[i], 1'b0);
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_timeout: %0d results outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_idle(input string name);
        tests_run++;
        if (bus.busy !== 1'b0 || bus.dbg_state !== ST_IDLE) begin
            fails++;
            $display("FAIL %s_idle: busy=%0b state=%0d, required busy=0 state=0",
                     name, bus.busy, bus.dbg_state);
        end
    endtask

    // Tests
    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        tests_run++;
        if (bus.decision !== '0 || bus.max_score !== '0 || bus.valid_out !== 1'b0 ||
            bus.busy !== 1'b0 || bus.rd_data !== '0 || bus.dbg_state !== ST_IDLE) begin
            fails++;
            $display("FAIL reset_values: dec=%0d score=%0d vo=%0b busy=%0b rd=%0d, required all 0",
                     bus.decision, bus.max_score, bus.valid_out, bus.busy, bus.rd_data);
        end
        @(negedge clk);
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_basic();
        int s[OUTPUT_NUM] = '{5, -3, 20, 7, 20, 0, 1, 2, 3, 4};
        run_frame(s, 0);
        drain("basic");
        tests_run++;
        if (bus.decision !== cls_idx_t'(2) || bus.max_score !== score_t'(20)) begin
            fails++;
            $display("FAIL basic_hold: dec=%0d score=%0d, required dec=2 score=20",
                     bus.decision, bus.max_score);
        end
        check_idle("basic");
    endtask

    task automatic test_negative();
        int s[OUTPUT_NUM] = '{-8, -2, -100, -2048, -9, -3, -2, -50, -7, -1};
        run_frame(s, 0);
        drain("negative");
        tests_run++;
        if (bus.decision !== cls_idx_t'(9) || bus.max_score !== score_t'(-1)) begin
            fails++;
            $display("FAIL negative_hold: dec=%0d score=%0d, required dec=9 score=-1",
                     bus.decision, bus.max_score);
        end
    endtask

    task automatic test_async_reset();
        int s[OUTPUT_NUM] = '{1, 2, 3, 4, 50, 6, 7, 8, 9, 10};
        bus.rd_addr = cls_idx_t'(9);
        for (int i = 0; i < 4; i++) beat(100 + i, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus.decision !== '0 || bus.max_score !== '0 || bus.valid_out !== 1'b0 ||
            bus.busy !== 1'b0 || bus.rd_data !== '0) begin
            fails++;
            $display("FAIL async_reset: dec=%0d score=%0d vo=%0b busy=%0b rd=%0d, required all 0",
                     bus.decision, bus.max_score, bus.valid_out, bus.busy, bus.rd_data);
        end
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        run_frame(s, 0);
        drain("after_reset");
        tests_run++;
        if (bus.decision !== cls_idx_t'(4) || bus.max_score !== score_t'(50)) begin
            fails++;
            $display("FAIL after_reset: dec=%0d score=%0d, required dec=4 score=50",
                     bus.decision, bus.max_score);
        end
    endtask

    task automatic test_back_to_back();
        int a[OUTPUT_NUM] = '{2047, 5, 2047, -1, 0, 100, 3, 2, 1, 0};
        int b[OUTPUT_NUM] = '{-5, 10, 20, 30, 99, 40, 50, 60, 70, 100};
        int n0;
        n0 = pulse_q.size();
        run_frame(a, 0);
        run_frame(b, 0);
        drain("back_to_back");
        tests_run++;
        if (pulse_q.size() != n0 + 2) begin
            fails++;
            $display("FAIL b2b_pulses: got %0d pulses, required 2", pulse_q.size() - n0);
        end else if (pulse_q[n0+1] - pulse_q[n0] != OUTPUT_NUM) begin
            fails++;
            $display("FAIL b2b_spacing: got %0d cycles, required %0d",
                     pulse_q[n0+1] - pulse_q[n0], OUTPUT_NUM);
        end
    endtask

    task automatic test_gaps_clear();
        int s[OUTPUT_NUM];
        int n0;
        cls_idx_t dec_before;
        // clear alone drops a partial frame and leaves the result untouched
        dec_before = bus.decision;
        for (int i = 0; i < 3; i++) beat(1000, 1'b0);
        clear_only();
        check_idle("clear_only");
        tests_run++;
        if (bus.decision !== dec_before) begin
            fails++;
            $display("FAIL clear_keeps_decision: dec=%0d, required %0d", bus.decision, dec_before);
        end
        n0 = pulse_q.size();
        for (int i = 0; i < 5; i++) begin
            beat(2000 - i, 1'b0);
            idle($urandom_range(0, 3));
        end
        tests_run++;
        if (bus.busy !== 1'b1 || pulse_q.size() != n0) begin
            fails++;
            $display("FAIL partial_frame: busy=%0b pulses=%0d, required busy=1 pulses=0",
                     bus.busy, pulse_q.size() - n0);
        end
        for (int i = 0; i < OUTPUT_NUM; i++) s[i] = $urandom_range(0, 1500) - 750;
        exp_q.push_back(expect_of(s));
        beat(s[0], 1'b1);
        for (int i = 1; i < OUTPUT_NUM; i++) begin
            idle($urandom_range(0, 3));
            beat(s[i], 1'b0);
        end
        drain("gaps_clear");
        check_idle("gaps_clear");
    endtask

    task automatic test_readback();
        int s[OUTPUT_NUM] = '{10, 11, 12, 13, 14, 15, 16, 17, 18, 19};
        int exp7;
        int exp12;
`ifdef FC_ARGMAX_READBACK_EN
        exp7  = 17;
        exp12 = 0;
`else
        exp7  = 0;
        exp12 = 0;
`endif
        run_frame(s, 0);
        drain("readback");
        bus.rd_addr = cls_idx_t'(7);
        #1;
        tests_run++;
        if (bus.rd_data !== score_t'(exp7)) begin
            fails++;
            $display("FAIL rd_addr7: got %0d, required %0d", bus.rd_data, exp7);
        end
        bus.rd_addr = cls_idx_t'(12);
        #1;
        tests_run++;
        if (bus.rd_data !== score_t'(exp12)) begin
            fails++;
            $display("FAIL rd_addr12: got %0d, required %0d", bus.rd_data, exp12);
        end
        clear_only();
        bus.rd_addr = cls_idx_t'(7);
        #1;
        tests_run++;
        if (bus.rd_data !== score_t'(exp7)) begin
            fails++;
            $display("FAIL rd_after_clear: got %0d, required %0d", bus.rd_data, exp7);
        end
    endtask

    initial begin
        tests_run    = 0;
        fails        = 0;
        cyc          = 0;
        prev_vo      = 1'b0;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        bus.clear    = 1'b0;
        bus.rd_addr  = '0;
        test_reset();
        test_basic();
        test_negative();
        test_async_reset();
        test_back_to_back();
        test_gaps_clear();
        test_readback();
        idle(3);
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL leftover_expected: %0d outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule

// File: doc/fc_argmax.md
# fc_argmax

Consumer end of the fully-connected layer's score stream: accepts one signed class score per `valid_in` beat, in class order 0..OUTPUT_NUM-1, and tracks the running maximum. After the last class of each frame it emits the winning class index and its score with a one-cycle valid pulse. It sits between the FC layer output and the top-level classification result port.

## Interface
- OUTPUT_NUM, 10, number of class scores per frame
- DATA_WIDTH, 12, score width (two's complement)
- IDX_WIDTH, 4, class index width; must satisfy 2**IDX_WIDTH >= OUTPUT_NUM
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- valid_in  in  1  score beat valid
- data_in  in  DATA_WIDTH  signed class score
- clear  in  1  synchronous frame re-align; discards any partial frame
- rd_addr  in  IDX_WIDTH  score readback address
- decision  out  IDX_WIDTH  winning class index, registered
- max_score  out  DATA_WIDTH  winning score, registered
- valid_out  out  1  one-cycle pulse, decision/max_score updated
- busy  out  1  partial frame in progress
- rd_data  out  DATA_WIDTH  stored score at rd_addr

## Operation
- Registers:
  - cnt (0..OUTPUT_NUM-1), the class index of the next beat
  - best_val, best_idx, the running maximum
- States: IDLE (cnt==0) and ACCUM (cnt!=0). busy = (state==ACCUM).
- Beat in IDLE: best_val<=data_in, best_idx<=0, cnt<=1, go to ACCUM.
- Beat in ACCUM: if data_in > best_val (signed, strict), then best_val<=data_in and best_idx<=cnt.
  - Ties keep the lower index.
  - cnt<=cnt+1.
- Beat with cnt==OUTPUT_NUM-1:
  - Final compare includes this beat.
  - decision/max_score load the final winner.
  - valid_out<=1 for the next cycle.
  - cnt<=0, state returns to IDLE.
- decision and max_score hold until the next frame completes.
- Cycles without valid_in leave all state unchanged. Gaps inside a frame are allowed.
- clear without valid_in: cnt<=0, state IDLE, best_* don't-care. decision, max_score and valid_out are unaffected.
- clear with valid_in in the same cycle: the partial frame is discarded and the beat is taken as class 0 of a new frame (cnt<=1).
- Reset values (async):
  - all outputs 0
  - cnt 0, state IDLE
  - best_val 0, best_idx 0
  - stored scores 0
- OUTPUT_NUM==1: every beat completes a frame with decision 0.

## Timing
- Latency: valid_out asserts the cycle after the last-class beat is sampled. decision/max_score are valid in that same cycle.
- valid_out is high for exactly one cycle per completed frame.
- Back-to-back frames need zero idle cycles:
  - a beat in the cycle after the last class is class 0 of the next frame
  - the valid_out of the previous frame coincides with it
- Throughput: one score per cycle.
- rst asserted mid-frame: immediate return to reset values. No valid_out is produced for the aborted frame.
- rd_data is a combinational read of registered storage. A score written on beat N is readable from the cycle after beat N.

## Configuration
- Macro: FC_ARGMAX_READBACK_EN.
- Defined:
  - each accepted beat writes data_in into score_mem[cnt], where cnt is the class slot
  - rd_data = score_mem[rd_addr] for rd_addr < OUTPUT_NUM, 0 otherwise
  - clear does not erase score_mem
- Undefined:
  - no score storage is built
  - rd_data is tied to 0
  - rd_addr is ignored
- Ports are present in both builds.

## Structure
- Shared package cnn_pkg:
  - DATA_WIDTH, OUTPUT_NUM, IDX_WIDTH constants
  - score_t typedef (signed [DATA_WIDTH-1:0])
  - cls_idx_t typedef
- One sub-module, fc_score_cmp: combinational signed strict greater-than on two score_t plus index select, returning the updated best_val/best_idx.
- Frame counter, FSM and output registers stay in the top module.

## Test plan
- Reset, then scores 5,-3,20,7,20,0,1,2,3,4 on 10 consecutive beats -> valid_out one cycle after beat 10, decision=2, max_score=20 (tie at class 4 keeps 2), busy low afterwards.
- All-negative frame -8,-2,-100,-2048,-9,-3,-2,-50,-7,-1 -> decision=9, max_score=-1 (signed compare, not unsigned).
- Two frames back-to-back with no gap, winners class 0 (value 2047) then class 9 (value 100) -> two single-cycle valid_out pulses exactly 10 cycles apart, decisions 0 then 9.
- Frame with random valid_in gaps, and clear asserted together with the 6th beat -> that beat becomes class 0 and the next 9 beats complete the frame. No valid_out occurs for the first 5 beats.
- rst pulsed asynchronously after beat 4 of a frame -> all outputs 0 immediately. The following full frame yields the correct decision.
- With FC_ARGMAX_READBACK_EN, frame 0..9 = 10,11,..,19 -> rd_addr=7 gives 17, rd_addr=12 gives 0. Without the macro, rd_data is always 0.
